// File: rtl/oq_stats_counters.sv
// Per-queue packet/byte statistics: live counters with wrap or saturate arithmetic,
// sticky overflow flags, atomic shadow snapshot and a 1-cycle indexed read port.
module oq_stats_counters #(
    parameter int unsigned NUM_QUEUES        = 5,
    parameter int unsigned CNTR_WIDTH        = 32,
    parameter int unsigned BYTE_WIDTH        = 16,
    parameter int unsigned SATURATE          = 0,
    parameter int unsigned CLEAR_ON_SNAPSHOT = 0,
    parameter int unsigned ADDR_WIDTH        = 8
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [NUM_QUEUES-1:0]           pkt_stored,
    input  logic [BYTE_WIDTH-1:0]           bytes_stored,
    input  logic [NUM_QUEUES-1:0]           pkt_removed,
    input  logic [NUM_QUEUES*BYTE_WIDTH-1:0] bytes_removed,
    input  logic [NUM_QUEUES-1:0]           pkt_dropped,
    input  logic [BYTE_WIDTH-1:0]           bytes_dropped,
    input  logic                            clr_all,
    input  logic                            snapshot_req,
    input  logic                            rd_req,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [CNTR_WIDTH-1:0]           rd_data,
    output logic                            rd_valid,
    output logic                            snapshot_done
);

    localparam int unsigned NUM_SLOTS = 6;
    localparam int unsigned QW        = ADDR_WIDTH - 3;

    logic [CNTR_WIDTH-1:0] live_q   [NUM_QUEUES][NUM_SLOTS];
    logic [CNTR_WIDTH-1:0] live_d   [NUM_QUEUES][NUM_SLOTS];
    logic [CNTR_WIDTH-1:0] shadow_q [NUM_QUEUES][NUM_SLOTS];
    logic [CNTR_WIDTH:0]   bump_res [NUM_QUEUES][NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  ovf_q    [NUM_QUEUES];
    logic [NUM_SLOTS-1:0]  ovf_d    [NUM_QUEUES];
    logic [NUM_SLOTS-1:0]  ev_en    [NUM_QUEUES];
    logic [BYTE_WIDTH-1:0] ev_amt   [NUM_QUEUES][NUM_SLOTS];

    logic [CNTR_WIDTH-1:0] rd_data_q;
    logic [CNTR_WIDTH-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  snapshot_done_q;
    logic                  live_clr;
    logic [QW-1:0]         rd_queue;
    logic [2:0]            rd_slot;

    // Returns {overflow, new_value}; overflow is a carry-out, or any event on a
    // saturated counter that is already pinned at all-ones.
    function automatic logic [CNTR_WIDTH:0] bump(
        input logic [CNTR_WIDTH-1:0] base,
        input logic                  en,
        input logic [BYTE_WIDTH-1:0] amt
    );
        logic [CNTR_WIDTH:0] sum;
        logic                ovf;
        sum = {1'b0, base} + (CNTR_WIDTH+1)'(amt);
        ovf = sum[CNTR_WIDTH] | ((SATURATE != 0) && (base == '1));
        if (!en)
            bump = {1'b0, base};
        else if (sum[CNTR_WIDTH] && (SATURATE != 0))
            bump = {1'b1, {CNTR_WIDTH{1'b1}}};
        else
            bump = {ovf, sum[CNTR_WIDTH-1:0]};
    endfunction

    assign live_clr = snapshot_req && (CLEAR_ON_SNAPSHOT != 0);
    assign rd_queue = rd_addr[ADDR_WIDTH-1:3];
    assign rd_slot  = rd_addr[2:0];

    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            ev_en[q] = {pkt_dropped[q], pkt_dropped[q],
                        pkt_removed[q], pkt_removed[q],
                        pkt_stored[q],  pkt_stored[q]};
            ev_amt[q][0] = BYTE_WIDTH'(1);
            ev_amt[q][1] = bytes_stored;
            ev_amt[q][2] = BYTE_WIDTH'(1);
            ev_amt[q][3] = bytes_removed[q*BYTE_WIDTH +: BYTE_WIDTH];
            ev_amt[q][4] = BYTE_WIDTH'(1);
            ev_amt[q][5] = bytes_dropped;
        end
    end

    // A clearing snapshot starts the live counter from zero so this cycle's event survives.
    always_comb begin
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                bump_res[q][s] = bump(live_clr ? '0 : live_q[q][s], ev_en[q][s], ev_amt[q][s]);
                live_d[q][s]   = bump_res[q][s][CNTR_WIDTH-1:0];
                ovf_d[q][s]    = ovf_q[q][s] | bump_res[q][s][CNTR_WIDTH];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            if (rd_queue == QW'(q)) begin
                case (rd_slot)
                    3'd0:    rd_data_d = shadow_q[q][0];
                    3'd1:    rd_data_d = shadow_q[q][1];
                    3'd2:    rd_data_d = shadow_q[q][2];
                    3'd3:    rd_data_d = shadow_q[q][3];
                    3'd4:    rd_data_d = shadow_q[q][4];
                    3'd5:    rd_data_d = shadow_q[q][5];
                    3'd6:    rd_data_d = CNTR_WIDTH'(ovf_q[q]);
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                ovf_q[q] <= '0;
                for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                    live_q[q][s]   <= '0;
                    shadow_q[q][s] <= '0;
                end
            end
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
            snapshot_done_q <= 1'b0;
        end else begin
            rd_valid_q      <= rd_req;
            snapshot_done_q <= snapshot_req;
            if (rd_req)
                rd_data_q <= rd_data_d;
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                if (clr_all) begin
                    ovf_q[q] <= '0;
                    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                        live_q[q][s]   <= '0;
                        shadow_q[q][s] <= '0;
                    end
                end else begin
                    ovf_q[q] <= ovf_d[q];
                    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
                        live_q[q][s] <= live_d[q][s];
                        if (snapshot_req)
                            shadow_q[q][s] <= live_q[q][s];
                    end
                end
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign snapshot_done = snapshot_done_q;

endmodule
